// File: rtl/apb_to_reg_native.sv
// APB3 slave to reg_native master bridge: one reg_native request per APB transfer,
// with address decode/alignment checks and a completion timeout so a hung target cannot stall the bus.
module apb_to_reg_native #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 6,
    parameter int                    APB_ADDR_WIDTH = 16,
    parameter int                    TIMEOUT        = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pready,
    output logic                      pslverr,

    output logic                      req_vld,
    input  logic                      req_rdy,
    output logic                      wr_en,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    input  logic                      ack_vld,
    output logic                      ack_rdy
);

    localparam int                 CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [CNT_W-1:0]        r_cnt;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    r_ack_rdy;

    logic                    w_access;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic                    w_dec_err;
    logic                    w_timeout;
    logic [ADDR_WIDTH-1:0]   w_word_addr;

    assign w_access       = psel & penable & ~pready;
    assign w_misaligned   = |paddr[1:0];
    assign w_out_of_range = |(paddr >> (ADDR_WIDTH + 2));
    assign w_dec_err      = w_misaligned | w_out_of_range;
    assign w_word_addr    = paddr[ADDR_WIDTH+1:2];
    assign w_timeout      = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An ack in WAIT_ACK takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_next = w_dec_err ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (w_timeout) begin
                    w_next = S_RESP;
                end else if (req_rdy) begin
                    w_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (ack_vld || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_vld = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        case (r_state)
            S_REQ: begin
                req_vld = 1'b1;
                wr_en   = r_write;
                rd_en   = ~r_write;
            end
            S_RESP: begin
                pready  = 1'b1;
                pslverr = r_err;
                prdata  = r_rdata;
            end
            default: begin
            end
        endcase
    end

    assign addr    = r_addr;
    assign wr_data = r_wdata;
    assign ack_rdy = r_ack_rdy;

    // Request fields are latched once at decode and held until the next accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_ack_rdy <= 1'b0;
        end else begin
            r_ack_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_dec_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= ERR_DATA;
                        end else begin
                            r_write <= pwrite;
                            r_addr  <= w_word_addr;
                            r_wdata <= pwdata;
                            r_err   <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= ERR_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (ack_vld) begin
                        r_err     <= 1'b0;
                        r_rdata   <= r_write ? '0 : rd_data;
                        r_ack_rdy <= 1'b1;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= ERR_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
